// File: rtl/rsa_mod_prod.sv
// rtl/rsa_mod_prod.sv - (a * 2^K) mod n pre-transform via bit-serial shift-and-subtract
module rsa_mod_prod #(
  parameter int W = 256,
  parameter int K = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_result,
  output logic         o_finished,
  output logic         o_busy,
  output logic         o_err
);
  localparam int CW = $clog2(W + K + 1);
  localparam logic [CW-1:0] C_HORNER = CW'(W);
  localparam logic [CW-1:0] C_LAST   = CW'(W + K - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  a_q, n_q, r_q;
  logic [CW-1:0] c_q;
  logic [W:0]    t, t_red;
  logic          in_bit, n_zero, unused_t_msb;

  assign n_zero = (i_n == '0);
  // a_q shifts left every step, so its MSB is a[W-1-c] throughout the Horner phase.
  assign in_bit = (c_q < C_HORNER) ? a_q[W-1] : 1'b0;
  assign t      = {r_q, in_bit};
  // r < n keeps t < 2n, so the reduced value always fits back into W bits.
  assign t_red  = (t >= {1'b0, n_q}) ? t - {1'b0, n_q} : t;
  assign unused_t_msb = t_red[W];

  assign o_finished = (state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = n_zero ? S_DONE : S_RUN;
      S_RUN:   if (c_q == C_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      a_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      o_result <= '0;
      o_busy   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            o_err  <= n_zero;
            if (n_zero) begin
              o_result <= '0;
            end else begin
              a_q <= i_a;
              n_q <= i_n;
              r_q <= '0;
              c_q <= '0;
            end
          end
        end
        S_RUN: begin
          r_q <= t_red[W-1:0];
          a_q <= a_q << 1;
          c_q <= c_q + 1'b1;
          if (c_q == C_LAST) o_result <= t_red[W-1:0];
        end
        S_DONE: o_busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_mod_prod.sv
// tb/tb_rsa_mod_prod.sv - scoreboard bench for rsa_mod_prod against a wide-modulo reference
module tb_rsa_mod_prod;
  localparam int W = 256;
  localparam int K = 256;
  localparam int NRAND = 140;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_n = '0;
  logic [W-1:0] o_result;
  logic         o_finished, o_busy, o_err;

  rsa_mod_prod #(.W(W), .K(K)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_a(i_a), .i_n(i_n),
    .o_result(o_result), .o_finished(o_finished), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] prev_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] n);
    logic [2*W-1:0] p, q;
    if (n == '0) return '0;
    p = {a, {K{1'b0}}};
    q = p % {{W{1'b0}}, n};
    return q[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    exp_t e;
    if (rst && o_finished) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_finished: o_finished high at cycle %0d with no job outstanding", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", o_result, e.res);
        chk("err", W'(o_err), W'(e.err));
        chk("latency", W'(cyc - e.acc), W'(e.lat));
      end
    end
  end

  // hold < 0 leaves i_start high; otherwise it drops hold+1 negedges after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] n, input int hold);
    exp_t         e;
    logic [W-1:0] held;
    held = (n == '0) ? '0 : prev_res;
    @(negedge clk);
    i_a = a;
    i_n = n;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    e.res = ref_model(a, n);
    e.err = (n == '0);
    e.acc = cyc;
    e.lat = (n == '0) ? 0 : W + K;
    sb.push_back(e);
    prev_res = e.res;
    chk("busy_at_accept", W'(o_busy), W'(1));
    chk("result_held", o_result, held);
    if (hold >= 0) begin
      repeat (hold) @(negedge clk);
      @(negedge clk);
      i_start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (o_busy === 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: o_busy still %b after %0d cycles", o_busy, k);
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", W'(sb.size()), W'(0));
    @(negedge clk);
    chk("busy_after_done", W'(o_busy), W'(0));
    chk("finished_after_done", W'(o_finished), W'(0));
  endtask

  logic [W-1:0] ta[7];
  logic [W-1:0] tn[7];
  int           th[7];

  initial begin
    logic [W-1:0] a, n, nmax;
    nmax = '1;
    repeat (2) @(negedge clk);
    chk("rst_result", o_result, '0);
    chk("rst_finished", W'(o_finished), W'(0));
    chk("rst_busy", W'(o_busy), W'(0));
    chk("rst_err", W'(o_err), W'(0));
    rst = 1'b1;

    ta = '{W'(3), W'(5), nmax, nmax - 1, nmax, rand_w(), W'(3)};
    tn = '{W'(7), nmax, nmax, nmax, W'(1), W'(0), W'(7)};
    th = '{0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      issue(ta[i], tn[i], th[i]);
    end
    wait_drain();

    // Start pulses and operand changes while running must be ignored.
    wait_idle();
    a = rand_w();
    n = rand_w() | W'(2);
    issue(a, n, 0);
    repeat (50) @(negedge clk);
    i_start = 1'b1;
    i_a = rand_w();
    i_n = rand_w();
    @(negedge clk);
    i_start = 1'b0;
    repeat (100) @(negedge clk);
    i_start = 1'b1;
    i_n = '0;
    @(negedge clk);
    i_start = 1'b0;
    wait_drain();

    // Reset in the middle of a run aborts it silently.
    wait_idle();
    issue(W'(3), W'(7), 0);
    repeat (199) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("abort_result", o_result, '0);
    chk("abort_finished", W'(o_finished), W'(0));
    chk("abort_busy", W'(o_busy), W'(0));
    chk("abort_err", W'(o_err), W'(0));
    repeat (3) begin
      @(negedge clk);
      chk("in_rst_finished", W'(o_finished), W'(0));
      chk("in_rst_busy", W'(o_busy), W'(0));
    end
    rst = 1'b1;
    prev_res = '0;
    wait_idle();
    issue(W'(3), W'(7), 0);
    wait_drain();

    // Back-to-back random jobs with i_start held high.
    wait_idle();
    for (int j = 0; j < NRAND; j++) begin
      a = rand_w();
      n = rand_w() >> $urandom_range(0, 250);
      if (n < W'(2)) n = W'(2);
      issue(a, n, -1);
      repeat (W + K + 1) @(posedge clk);
    end
    @(negedge clk);
    i_start = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
